// File: rtl/snapshot_serializer.sv
// Serializes a wide commit snapshot into WORD_W-bit AXI-Stream beats, LSW first,
// and pulses data_next once the final beat is accepted so upstream can reload.
module snapshot_serializer #(
  parameter int SNAP_W = 1664,
  parameter int WORD_W = 32
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic              en,
  input  logic              snap_load,
  input  logic [SNAP_W-1:0] snap_data,
  output logic [WORD_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              data_next,
  output logic              busy,
  output logic [31:0]       snap_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int NWORDS = SNAP_W / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} state_t;

  state_t                          state_q, state_d;
  logic [NWORDS-1:0][WORD_W-1:0]   shadow_q, shadow_d;
  logic [IDX_W-1:0]                idx_q, idx_d, idx_nx;
  logic [WORD_W-1:0]               tdata_q, tdata_d;
  logic                            tvalid_q, tvalid_d;
  logic                            tlast_q, tlast_d;
  logic                            dn_q, dn_d;
  logic                            busy_q, busy_d;
  logic [31:0]                     snap_cnt_q, snap_cnt_d;
  logic [15:0]                     drop_cnt_q, drop_cnt_d;
  logic                            xfer;

  assign xfer   = tvalid_q & m_tready;
  assign idx_nx = idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    dn_d       = 1'b0;
    busy_d     = busy_q;
    snap_cnt_d = snap_cnt_q;
    drop_cnt_d = drop_cnt_q;

    // A load that arrives while a snapshot is in flight is lost; count it.
    if (en && snap_load && (state_q != IDLE) && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;

    if (!en) begin
      state_d  = IDLE;
      idx_d    = '0;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          busy_d = 1'b0;
          if (snap_load) begin
            shadow_d = snap_data;
            idx_d    = '0;
            tdata_d  = snap_data[WORD_W-1:0];
            tvalid_d = 1'b1;
            tlast_d  = (NWORDS == 1);
            busy_d   = 1'b1;
            state_d  = SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (idx_q == LAST_IDX) begin
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              dn_d     = 1'b1;
              state_d  = DONE;
            end else begin
              // Outputs are registered, so the next word is fetched one beat ahead.
              idx_d   = idx_nx;
              tdata_d = shadow_q[idx_nx];
              tlast_d = (idx_nx == LAST_IDX);
            end
          end
        end
        DONE: begin
          snap_cnt_d = snap_cnt_q + 32'd1;
          busy_d     = 1'b0;
          idx_d      = '0;
          state_d    = IDLE;
        end
        default: begin
          state_d  = IDLE;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      idx_q      <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      dn_q       <= 1'b0;
      busy_q     <= 1'b0;
      snap_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      dn_q       <= dn_d;
      busy_q     <= busy_d;
      snap_cnt_q <= snap_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign m_tdata   = tdata_q;
  assign m_tvalid  = tvalid_q;
  assign m_tlast   = tlast_q;
  assign data_next = dn_q;
  assign busy      = busy_q;
  assign snap_cnt  = snap_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_snapshot_serializer.sv
// Directed + randomized bench for snapshot_serializer; expected beats come from a
// word queue filled when each snapshot is built, compared against captured beats.
module tb_snapshot_serializer;
  localparam int SNAP_W = 1664;
  localparam int WORD_W = 32;
  localparam int NW     = SNAP_W / WORD_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b1;
  logic              snap_load = 1'b0;
  logic [SNAP_W-1:0] snap_data = '0;
  logic              m_tready = 1'b0;
  logic [WORD_W-1:0] m_tdata;
  logic              m_tvalid, m_tlast, data_next, busy;
  logic [31:0]       snap_cnt;
  logic [15:0]       drop_cnt;

  snapshot_serializer #(.SNAP_W(SNAP_W), .WORD_W(WORD_W)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .en(en), .snap_load(snap_load),
    .snap_data(snap_data), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .data_next(data_next), .busy(busy),
    .snap_cnt(snap_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Beat capture and AXIS hold-while-stalled monitor.
  logic [31:0] beats[$];
  logic        lasts[$];
  int          dn_count = 0;
  int          stab_viol = 0;
  logic        stall_p = 1'b0, ok_p = 1'b0, last_p = 1'b0;
  logic [31:0] data_p = '0;
  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      beats.push_back(m_tdata);
      lasts.push_back(m_tlast);
    end
    if (data_next) dn_count <= dn_count + 1;
    if (stall_p && ok_p && !(m_tvalid && m_tdata == data_p && m_tlast == last_p))
      stab_viol <= stab_viol + 1;
    stall_p <= m_tvalid && !m_tready;
    ok_p    <= !rst && en;
    data_p  <= m_tdata;
    last_p  <= m_tlast;
  end

  int          checks = 0;
  int          errors = 0;
  int          ready_mode = 0;
  int          c0 = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    snap_load = 1'b0;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ((cyc % 3) == 0);
      2:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = ((cyc % 2) == 0);
    endcase
  endtask

  // Build a snapshot (fixed pattern or random) and queue its words as expected beats.
  task automatic fill(input bit pat);
    logic [31:0] w;
    for (int i = 0; i < NW; i++) begin
      w = pat ? (32'hA500_0000 + 32'(i)) : $urandom;
      snap_data[i*WORD_W +: WORD_W] = w;
      exp_q.push_back(w);
    end
  endtask

  task automatic garbage();
    for (int i = 0; i < NW; i++) snap_data[i*WORD_W +: WORD_W] = $urandom;
  endtask

  task automatic load();
    snap_load = 1'b1;
    c0 = cyc;
  endtask

  task automatic wait_dn(input int budget, input int d1, input int d2);
    int n = 0;
    while (!data_next && n < budget) begin
      step();
      n++;
      if (!data_next && (cyc == c0 + d1 || cyc == c0 + d2)) begin
        garbage();
        snap_load = 1'b1;
      end
    end
    chk("dn_seen", data_next, 1);
  endtask

  task automatic cmp_stream(input int base, input string tag);
    int n = beats.size() - base;
    chk({tag, "_nbeats"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      chk({tag, "_data"}, beats[base+i], exp_q[i]);
      chk({tag, "_last"}, lasts[base+i], ((i % NW) == NW - 1));
    end
    exp_q.delete();
  endtask

  initial begin
    int base, dn0, sc, dc, nl;
    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_dn", data_next, 0);
    chk("rst_busy", busy, 0);
    chk("rst_snap_cnt", snap_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    step();

    // 1: pattern snapshot, always ready, exact latency
    ready_mode = 0; base = beats.size(); dn0 = dn_count;
    fill(1); load();
    step();
    chk("t1_first_valid", m_tvalid, 1);
    chk("t1_first_word", m_tdata, 32'hA500_0000);
    chk("t1_first_busy", busy, 1);
    wait_dn(300, -100, -100);
    chk("t1_dn_cycle", cyc, c0 + 53);
    chk("t1_dn_busy", busy, 1);
    chk("t1_dn_tvalid", m_tvalid, 0);
    step();
    chk("t1_idle_busy", busy, 0);
    chk("t1_snap_cnt", snap_cnt, 1);
    chk("t1_last_word", beats[beats.size()-1], 32'hA500_0033);
    cmp_stream(base, "t1");
    chk("t1_dn_once", dn_count - dn0, 1);

    // 2: same snapshot, ready one cycle in three
    ready_mode = 1; base = beats.size(); dn0 = dn_count;
    fill(1); load();
    wait_dn(600, -100, -100);
    repeat (5) step();
    cmp_stream(base, "t2");
    chk("t2_dn_once", dn_count - dn0, 1);
    chk("t2_snap_cnt", snap_cnt, 2);
    chk("t2_stable", stab_viol, 0);

    // 3: random snapshot, random ready, two loads while busy
    ready_mode = 2; base = beats.size();
    fill(0); load();
    wait_dn(1000, 10, 20);
    step();
    chk("t3_drop_cnt", drop_cnt, 2);
    chk("t3_snap_cnt", snap_cnt, 3);
    cmp_stream(base, "t3");

    // 4: reset mid-stream, then a clean restart
    ready_mode = 0; dn0 = dn_count;
    fill(0); load();
    repeat (20) step();
    chk("t4_pre_valid", m_tvalid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_tvalid", m_tvalid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_tdata", m_tdata, 0);
    chk("t4_snap_cnt", snap_cnt, 0);
    chk("t4_drop_cnt", drop_cnt, 0);
    exp_q.delete();
    repeat (60) step();
    chk("t4_no_dn", dn_count - dn0, 0);
    ready_mode = 3; base = beats.size();
    fill(0); load();
    wait_dn(600, -100, -100);
    step();
    cmp_stream(base, "t4r");
    chk("t4r_snap_cnt", snap_cnt, 1);

    // 5: en low mid-stream aborts without touching counters
    ready_mode = 0; dn0 = dn_count;
    garbage(); load();
    step();
    chk("t5_ready_load_drop", drop_cnt, 0);
    fill(0); exp_q.delete();
    load();
    repeat (30) step();
    sc = int'(snap_cnt); dc = int'(drop_cnt);
    en = 1'b0;
    step();
    chk("t5_tvalid", m_tvalid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_tlast", m_tlast, 0);
    snap_load = 1'b1;
    step();
    chk("t5_load_ignored", m_tvalid, 0);
    chk("t5_drop_hold", drop_cnt, dc);
    repeat (60) step();
    chk("t5_snap_hold", snap_cnt, sc);
    chk("t5_no_dn", dn_count - dn0, 0);
    en = 1'b1;
    step();
    base = beats.size();
    fill(0); load();
    wait_dn(300, -100, -100);
    step();
    cmp_stream(base, "t5r");
    chk("t5r_snap_cnt", snap_cnt, sc + 1);

    // 6: three back-to-back snapshots reloaded on data_next
    ready_mode = 2; base = beats.size(); sc = int'(snap_cnt);
    for (int r = 0; r < 3; r++) begin
      fill(0); load();
      wait_dn(1000, -100, -100);
      step();
    end
    chk("t6_snap_cnt", snap_cnt, sc + 3);
    nl = 0;
    for (int i = base; i < lasts.size(); i++) if (lasts[i]) nl++;
    chk("t6_tlasts", nl, 3);
    chk("t6_total", beats.size() - base, 3 * NW);
    cmp_stream(base, "t6");
    chk("stable_all", stab_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
